// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU main controller: IF/ID/EX/MEM/WB sequencer.
// Optional MEM_WAIT_EN: stall IF and MEM until mem_ready is high.
module mc_control_fsm #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         read_sel,
  output logic [1:0]         wr_sel,
  output logic [1:0]         wb_sel,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic               halted,
  output logic               illegal
);

  localparam logic [STATE_W-1:0] S_IF   = 3'd0;
  localparam logic [STATE_W-1:0] S_ID   = 3'd1;
  localparam logic [STATE_W-1:0] S_EX   = 3'd2;
  localparam logic [STATE_W-1:0] S_MEM  = 3'd3;
  localparam logic [STATE_W-1:0] S_WB   = 3'd4;
  localparam logic [STATE_W-1:0] S_HALT = 3'd5;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL  = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic [OP_W-1:0]    r_op;
  logic               w_rdy;

  logic w_id_ex;
  logic w_id_j;
  logic w_id_jal;
  logic w_id_halt;
  logic w_id_ill;

`ifdef MEM_WAIT_EN
  assign w_rdy = mem_ready;
`else
  // Memory is single-cycle; mem_ready has no effect.
  assign w_rdy = mem_ready | 1'b1;
`endif

  assign w_id_ex   = (opcode == OP_R)  || (opcode == OP_ADDI) ||
                     (opcode == OP_LW) || (opcode == OP_SW)   ||
                     (opcode == OP_BEQ);
  assign w_id_j    = (opcode == OP_J);
  assign w_id_jal  = (opcode == OP_JAL);
  assign w_id_halt = (opcode == OP_HALT);
  assign w_id_ill  = !(w_id_ex || w_id_j || w_id_jal || w_id_halt);

  // State register and opcode latch (captured during ID).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IF;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ID) r_op <= opcode;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:   w_next = w_rdy ? S_ID : S_IF;
      S_ID: begin
        if (w_id_ex)        w_next = S_EX;
        else if (w_id_jal)  w_next = S_WB;
        else if (w_id_halt) w_next = S_HALT;
        else                w_next = S_IF;
      end
      S_EX: begin
        if (r_op == OP_R || r_op == OP_ADDI)     w_next = S_WB;
        else if (r_op == OP_LW || r_op == OP_SW) w_next = S_MEM;
        else                                     w_next = S_IF;
      end
      S_MEM: begin
        if (!w_rdy)              w_next = S_MEM;
        else if (r_op == OP_LW)  w_next = S_WB;
        else                     w_next = S_IF;
      end
      S_WB:   w_next = S_IF;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  assign state = reset ? '0 : r_state;

  // Moore output decode; everything forced low during reset.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    read_sel   = 2'b00;
    wr_sel     = 2'b00;
    wb_sel     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IF: begin
          mem_read  = 1'b1;
          ir_write  = w_rdy;
          pc_write  = w_rdy;
          alu_src_b = 2'b01;
        end
        S_ID: begin
          alu_src_b = 2'b11;
          if (w_id_j) begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
          end
          if (w_id_ill) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_EX: begin
          alu_src_a = 1'b1;
          if (r_op == OP_R) begin
            alu_op = 2'b10;
          end else if (r_op == OP_BEQ) begin
            alu_op     = 2'b01;
            pc_src     = 2'b01;
            pc_write   = zero;
            instr_done = 1'b1;
          end else begin
            alu_src_b = 2'b10;
          end
        end
        S_MEM: begin
          if (r_op == OP_LW) begin
            mem_read = 1'b1;
          end else begin
            mem_write  = 1'b1;
            instr_done = w_rdy;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          if (r_op == OP_R) begin
            wr_sel = 2'b01;
          end else if (r_op == OP_LW) begin
            wb_sel = 2'b01;
          end else if (r_op == OP_JAL) begin
            wr_sel   = 2'b10;
            wb_sel   = 2'b10;
            pc_src   = 2'b10;
            pc_write = 1'b1;
          end
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle CPU main controller. Sequences the datapath one state per clock through IF, ID, EX, MEM and WB. Drives the register-2 read-address select, the write-destination select, the ALU operand/op selects, the PC source, and all write and memory strobes. Sits between the instruction register's opcode field and the datapath muxes and register file.

Parameters:
OP_W, 6, opcode field width
STATE_W, 3, state register width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
opcode  input  OP_W  instruction[31:26], valid from ID onward
zero  input  1  ALU zero flag, sampled in EX of BEQ
mem_ready  input  1  memory ready; used only with MEM_WAIT_EN
pc_write  output  1  PC load enable
ir_write  output  1  instruction register load
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
reg_write  output  1  register file write enable
read_sel  output  2  register-2 read mux select: 00 rt, 01 rd, 10 forced zero
wr_sel  output  2  write-destination select: 00 rt, 01 rd, 10 $31
wb_sel  output  2  write-back data: 00 ALUOut, 01 MDR, 10 PC
alu_src_a  output  1  0 PC, 1 register A
alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
alu_op  output  2  00 add, 01 sub, 10 funct-decode
pc_src  output  2  00 ALU result, 01 ALUOut (branch), 10 jump target
state  output  STATE_W  current state, for debug
instr_done  output  1  one-cycle pulse on the last cycle of each instruction
halted  output  1  high in HALT state
illegal  output  1  one-cycle pulse on an undefined opcode in ID

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Values 6 and 7 are unreachable and return to IF on the next clock.
- Reset: synchronous. While reset=1, the state loads IF and every output is forced to 0 (state reads 0). The first cycle after reset deasserts is IF.
- Outputs are Moore-decoded from the state register and an opcode register latched in ID. No output depends combinationally on opcode in IF.
- IF: mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, pc_write=1. Next state is ID.
- ID: latch opcode; read_sel=00; alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Transitions by opcode:
  - R(000000), ADDI(001000), LW(100011), SW(101011), BEQ(000100): EX
  - J(000010): pc_src=10, pc_write=1, instr_done=1, then IF
  - JAL(000011): WB
  - HALT(111111): HALT
  - any other opcode: illegal=1, instr_done=1, then IF (no state change)
- EX:
  - R: alu_src_a=1, alu_src_b=00, alu_op=10, then WB
  - ADDI/LW/SW: alu_src_a=1, alu_src_b=10, alu_op=00; ADDI goes to WB, LW/SW go to MEM
  - BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero, instr_done=1, then IF
- MEM:
  - LW: mem_read=1, then WB
  - SW: mem_write=1, instr_done=1, then IF
- WB: reg_write=1, instr_done=1, then IF.
  - R: wr_sel=01, wb_sel=00
  - ADDI: wr_sel=00, wb_sel=00
  - LW: wr_sel=00, wb_sel=01
  - JAL: wr_sel=10, wb_sel=10, pc_src=10, pc_write=1
- Latencies in cycles: J 2, BEQ 3, JAL 3, R 4, ADDI 4, SW 4, LW 5.
- HALT: halted=1, all strobes 0. Only reset leaves HALT.
- All outputs not listed for a state are 0.
- Reset mid-instruction: the next state is IF and no strobe fires in the reset cycle.

Optional Feature:
MEM_WAIT_EN
- Defined: in IF and MEM the FSM holds its state while mem_ready=0.
  - While held, mem_read/mem_write stay asserted.
  - pc_write, ir_write, reg_write and instr_done are suppressed until the cycle with mem_ready=1; that cycle then proceeds exactly as the no-wait case.
- Undefined: mem_ready is ignored and memory is treated as single-cycle.

Test Plan:
- Reset held 3 cycles, then release -> all outputs 0 during reset; first cycle state=0, pc_write=1, ir_write=1, mem_read=1.
- LW opcode 100011 -> states 0,1,2,3,4; reg_write=1 only in state 4 with wr_sel=00, wb_sel=01; instr_done pulses once; 5 cycles total.
- BEQ 000100 with zero=1, then with zero=0 -> pc_write=1 in EX only when zero=1, pc_src=01 in both cases; returns to IF after 3 cycles.
- JAL 000011 -> WB state with reg_write=1, wr_sel=10, wb_sel=10, pc_write=1, pc_src=10; 3 cycles.
- Opcode 010101, then HALT 111111 -> illegal pulses 1 cycle in ID and FSM returns to IF; HALT then sets halted=1 and holds through 10 cycles until reset.
- MEM_WAIT_EN defined, SW with mem_ready low 2 cycles in MEM -> state stays 3 for 3 cycles, mem_write high throughout, instr_done only on the mem_ready=1 cycle.
